// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption round datapath.
// Holds the state type, byte count and the round-sequencer FSM encoding.
package aes_dec_pkg;

    localparam int NUM_BYTES = 16;

    typedef logic [8*NUM_BYTES-1:0] aes_state_t;

    // Common sequencer states; sibling round blocks use the same encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } dec_fsm_e;

endpackage

// File: rtl/inv_sbox_element.sv
// Single AES inverse S-box lane: purely combinational byte substitution.
module inv_sbox_element (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        out_byte = 8'h00;
        case (in_byte)
            8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5;
            8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
            8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e;
            8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
            8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82;
            8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
            8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44;
            8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
            8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32;
            8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
            8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b;
            8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
            8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66;
            8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
            8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49;
            8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
            8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64;
            8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
            8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc;
            8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
            8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50;
            8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
            8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57;
            8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
            8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00;
            8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
            8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05;
            8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
            8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f;
            8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
            8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03;
            8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
            8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41;
            8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
            8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce;
            8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
            8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22;
            8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
            8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8;
            8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
            8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71;
            8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
            8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e;
            8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
            8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b;
            8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
            8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe;
            8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
            8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33;
            8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
            8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59;
            8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
            8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9;
            8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
            8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f;
            8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
            8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d;
            8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
            8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c;
            8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
            8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e;
            8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
            8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63;
            8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
            default: out_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed InvSubBytes: substitutes a 128-bit state LANES bytes per cycle
// through shared inverse S-box lanes, with valid/ready on both sides.
module inv_sub_bytes_seq
    import aes_dec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int GROUPS = NUM_BYTES / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    dec_fsm_e                   state_q, state_d;
    logic [GW-1:0]              grp_q, grp_d;
    logic [NUM_BYTES-1:0][7:0]  work_q, work_d;

    logic [3:0] lane_sel [LANES];
    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Byte i of the state sits in packed slot NUM_BYTES-1-i, so lane k of group g picks that slot.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_sel[k] = 4'(NUM_BYTES - 1 - (int'(grp_q) * LANES + k));
            lane_in[k]  = work_q[lane_sel[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        inv_sbox_element u_sbox (
            .in_byte  (lane_in[k]),
            .out_byte (lane_out[k])
        );
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    grp_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int k = 0; k < LANES; k++) begin
                    work_d[lane_sel[k]] = lane_out[k];
                end
                if (grp_q == LAST_GRP) begin
                    grp_d   = '0;
                    state_d = DONE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
        end
    end

    // Handshake outputs come only from registered state; rst just masks in_ready.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SUB) || (state_q == DONE);
    assign out_state = out_valid ? 128'(work_q) : '0;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq against a GF(2^8)-derived InvSubBytes model.
module tb_inv_sub_bytes_seq;
    import aes_dec_pkg::*;

    localparam logic [127:0] ID_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ID_OUT = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    logic         sw_in_valid, sw_out_ready;
    logic [127:0] sw_in_state;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic         sw_busy      [4];
    logic [127:0] sw_out_state [4];
    int           sw_lanes     [4] = '{1, 2, 8, 16};

    int           checks = 0;
    int           fails  = 0;
    logic [7:0]   inv_tbl [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    for (genvar p = 0; p < 4; p++) begin : g_sweep
        inv_sub_bytes_seq #(.LANES(p == 0 ? 1 : p == 1 ? 2 : p == 2 ? 8 : 16)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[p]),
            .in_state  (sw_in_state),
            .out_valid (sw_out_valid[p]),
            .out_ready (sw_out_ready),
            .out_state (sw_out_state[p]),
            .busy      (sw_busy[p])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from field inverse + affine map, then inverted into a lookup.
    task automatic build_inv_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tbl[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one block, then waits for out_valid; consumes it if out_ready is high.
    task automatic run_block(input logic [127:0] blk, output int lat, output logic [127:0] res);
        int guard;
        in_valid = 1'b1;
        in_state = blk;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        in_state = rand128();
        lat = -1;
        res = '0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (out_valid) begin
                lat = n;
                res = out_state;
                break;
            end
        end
        if (lat > 0 && out_ready) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_state = rand128(); out_ready = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_in_state = '0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_state !== 128'h0) begin fails++; $display("[TB] FAIL reset_out_state: got %h want 0", out_state); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
        step();
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_no_accept: busy got %b want 0", busy); end
    endtask

    task automatic test_identity();
        int lat;
        logic [127:0] res;
        out_ready = 1'b1;
        run_block(ID_IN, lat, res);
        checks++; if (lat != 4) begin fails++; $display("[TB] FAIL identity_latency: got %0d want 4", lat); end
        checks++; if (res !== ID_OUT) begin fails++; $display("[TB] FAIL identity_result: got %h want %h", res, ID_OUT); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL identity_drain: out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL identity_idle: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_uniform();
        logic [127:0] ins  [4];
        logic [127:0] outs [4];
        int lat;
        logic [127:0] res;
        ins[0] = {16{8'h63}}; outs[0] = {16{8'h00}};
        ins[1] = {16{8'h16}}; outs[1] = {16{8'hff}};
        ins[2] = {8{16'h5200}}; outs[2] = {8{16'h4852}};
        ins[3] = rand128(); outs[3] = model(ins[3]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_block(ins[i], lat, res);
            checks++; if (res !== outs[i]) begin fails++; $display("[TB] FAIL uniform_%0d: got %h want %h", i, res, outs[i]); end
            checks++; if (lat != 4) begin fails++; $display("[TB] FAIL uniform_lat_%0d: got %0d want 4", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] blk, res, want;
        blk = rand128();
        want = model(blk);
        out_ready = 1'b0;
        run_block(blk, lat, res);
        checks++; if (res !== want) begin fails++; $display("[TB] FAIL bp_result: got %h want %h", res, want); end
        for (int c = 0; c < 10; c++) begin
            checks++; if (out_state !== want) begin fails++; $display("[TB] FAIL bp_stable_%0d: got %h want %h", c, out_state, want); end
            checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid_%0d: got %b want 1", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready_%0d: got %b want 0", c, in_ready); end
            in_valid = (c == 3);
            in_state = rand128();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_one_transfer: out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_in_ready_after: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_pulse_ignored: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_sub();
        int lat;
        logic [127:0] blk, res, want;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_state = rand128();
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (out_state !== 128'h0) begin fails++; $display("[TB] FAIL midrst_out_state: got %h want 0", out_state); end
        rst = 1'b0;
        blk = rand128();
        want = model(blk);
        run_block(blk, lat, res);
        checks++; if (res !== want) begin fails++; $display("[TB] FAIL midrst_next_result: got %h want %h", res, want); end
        checks++; if (lat != 4) begin fails++; $display("[TB] FAIL midrst_next_latency: got %0d want 4", lat); end
    endtask

    task automatic test_param_sweep();
        int lat [4];
        logic [127:0] res [4];
        for (int p = 0; p < 4; p++) begin lat[p] = -1; res[p] = '0; end
        sw_out_ready = 1'b1;
        sw_in_state = ID_IN;
        sw_in_valid = 1'b1;
        for (int p = 0; p < 4; p++) begin
            checks++; if (sw_in_ready[p] !== 1'b1) begin fails++; $display("[TB] FAIL sweep_ready_L%0d: got %b want 1", sw_lanes[p], sw_in_ready[p]); end
        end
        step();
        sw_in_valid = 1'b0;
        sw_in_state = rand128();
        for (int n = 1; n <= 24; n++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                if (sw_out_valid[p] && lat[p] < 0) begin
                    lat[p] = n;
                    res[p] = sw_out_state[p];
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            checks++; if (lat[p] != 16 / sw_lanes[p]) begin fails++; $display("[TB] FAIL sweep_latency_L%0d: got %0d want %0d", sw_lanes[p], lat[p], 16 / sw_lanes[p]); end
            checks++; if (res[p] !== ID_OUT) begin fails++; $display("[TB] FAIL sweep_result_L%0d: got %h want %h", sw_lanes[p], res[p], ID_OUT); end
        end
    endtask

    task automatic test_back_to_back();
        int got;
        logic [127:0] want;
        got = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        fork
            begin : producer
                logic [127:0] blk;
                int guard;
                for (int i = 0; i < 100; i++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        step();
                    end
                    blk = rand128();
                    exp_q.push_back(model(blk));
                    in_valid = 1'b1;
                    in_state = blk;
                    guard = 0;
                    while (!in_ready && guard < 2000) begin
                        step();
                        guard++;
                    end
                    if (guard >= 2000) begin
                        fails++;
                        $display("[TB] FAIL b2b_accept_timeout: block %0d not accepted", i);
                        break;
                    end
                    step();
                    in_valid = 1'b0;
                    in_state = rand128();
                end
            end
            begin : consumer
                for (int cyc = 0; cyc < 20000 && got < 100; cyc++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL b2b_extra_output: got %h want none", out_state);
                        end else begin
                            want = exp_q.pop_front();
                            if (out_state !== want) begin
                                fails++;
                                $display("[TB] FAIL b2b_block_%0d: got %h want %h", got, out_state, want);
                            end
                        end
                        got++;
                    end
                    step();
                end
            end
        join
        out_ready = 1'b1;
        checks++; if (got != 100) begin fails++; $display("[TB] FAIL b2b_count: got %0d want 100", got); end
        checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        build_inv_table();
        test_reset();
        test_identity();
        test_uniform();
        test_backpressure();
        test_reset_mid_sub();
        test_param_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Time-multiplexed InvSubBytes engine for the decryption round datapath. It accepts one 128-bit AES state over a valid/ready handshake and substitutes all 16 bytes through `LANES` shared `inv_sbox_element` instances, one group per cycle. It presents the result on a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decrypt round, trading latency for S-box area.

## Interface
- `LANES`, default 4: number of `inv_sbox_element` instances. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_state` holds a block to substitute.
- `in_ready` output 1: block can accept input; high only in IDLE and while `rst` is low.
- `in_state` input 128: input state. Byte i is `in_state[127-8i -: 8]`, i = 0..15.
- `out_valid` output 1: `out_state` holds a completed result.
- `out_ready` input 1: downstream accepts the result.
- `out_state` output 128: substituted state, same byte ordering as `in_state`.
- `busy` output 1: high in SUB or DONE.

## Operation
- **IDLE.** `in_ready` = 1.
  - On `in_valid && in_ready`: load `in_state` into the work register, set the group counter to 0, go to SUB.
- **SUB.** Each cycle, bytes `g*LANES .. g*LANES+LANES-1` of the work register go through the lanes. The results are written back in place. All other bytes hold.
  - `g` is the group counter, width clog2(16/LANES), minimum 1 bit.
  - On the last group (`g == 16/LANES-1`): go to DONE and clear the counter. The counter never wraps inside SUB.
- **DONE.** `out_valid` = 1 and `out_state` = work register, held stable.
  - On `out_ready`: go to IDLE.
  - `in_valid` is ignored in DONE; there is no accept-while-draining.
- `in_state` is sampled only on the accept edge. Changes after that edge have no effect.
- **Reset values (any state, any cycle):**
  - FSM = IDLE, counter = 0, work register = 0.
  - `out_valid` = 0, `busy` = 0, `out_state` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` drops.
- **Reset mid-operation.** A block in SUB or DONE is discarded with no output and no partial result visible. An `in_valid` coincident with `rst` is not accepted.
- **Simultaneous events.** `out_ready` high while not in DONE has no effect. `out_valid` and `in_ready` are never both high.

## Timing
- Accept on edge E0. Groups are substituted on edges E1..E(16/LANES). `out_valid` rises immediately after edge E(16/LANES).
  - Latency is 16/LANES clocks: 4 for the default, 1 for LANES=16, 16 for LANES=1.
- With `out_ready` held high, DONE lasts one cycle and IDLE lasts at least one. Maximum throughput is one block per 16/LANES + 2 cycles.
- The S-box path is purely combinational from the work register to its own D input. There is no additional pipeline register.
- `in_ready`, `out_valid` and `busy` are decoded from registered FSM state only. No combinational path runs from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `aes_dec_pkg` holds:
  - `NUM_BYTES = 16`.
  - The `aes_state_t` 128-bit typedef.
  - The FSM enum `{IDLE, SUB, DONE}`, also used by sibling round sequencers.
- Sub-module: `inv_sbox_element`, instantiated `LANES` times in a generate loop. Lane k maps to byte `g*LANES+k` through a per-lane mux on the work register.
- No other sub-modules; FSM, counter and work register live in this module.

## Test plan
- **Identity table.** Input bytes 0x63,7c,77,7b,f2,6b,6f,c5,30,01,67,2b,fe,d7,ab,76 with `out_ready`=1 → output bytes 0x00..0x0f. `out_valid` rises exactly 4 cycles after the accept edge.
- **Uniform and edge values.**
  - All bytes 0x63 → all 0x00.
  - All bytes 0x16 → all 0xff.
  - Alternating 0x52/0x00 → alternating 0x48/0x52.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles after `out_valid`. Required: `out_state` stable, `in_ready`=0, a pulsed `in_valid` ignored. Raising `out_ready` gives exactly one transfer, then `in_ready`=1 on the next cycle.
- **Reset mid-SUB.** Assert `rst` on the 2nd SUB cycle. Required: the next cycle shows `out_valid`=0, `busy`=0, `out_state`=0. A new block accepted after reset completes correctly with no residue.
- **Parameter sweep.** LANES=1, 2, 8, 16 with the identity vector. Required latency is 16, 8, 2 and 1 respectively, with identical results.
- **Back-to-back stream.** 100 random blocks, random `in_valid`/`out_ready` stalls, checked against a reference InvSubBytes model. Required: in-order, no drop, no duplicate.
